// File: rtl/note_uart_pkg.sv
// Shared types and helpers for the note-event UART: FSM states, packet sync byte, event width
// and the rounded baud divider.
package note_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         EVT_W     = 12;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/note_event_uart_if.sv
// Note-event bus: event strobe and fields toward the UART block, serial line and status back.
interface note_event_uart_if;
  logic [7:0] note;
  logic [3:0] note_dur;
  logic       new_note;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  modport master (output note, note_dur, new_note, input tx, busy, fifo_full, overflow);
  modport slave  (input note, note_dur, new_note, output tx, busy, fifo_full, overflow);
endinterface

// File: rtl/note_evt_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit so full/empty come from the MSB compare.
module note_evt_fifo
  import note_uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [EVT_W-1:0] wdata,
  output logic [EVT_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/note_event_uart.sv
// Buffers note events and sends each as a framed 8N1 UART packet (A5, note, dur).
// Define NOTE_UART_CHECKSUM_EN to append an XOR checksum byte to every packet.
module note_event_uart
  import note_uart_pkg::*;
#(
  parameter int CLK_HZ     = 6_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input logic              clk,
  input logic              reset,
  note_event_uart_if.slave bus
);

  localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
`ifdef NOTE_UART_CHECKSUM_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif

  if (BAUD_DIV < 4) begin : g_baud_chk
    $error("note_event_uart: BAUD_DIV must be >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("note_event_uart: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  function automatic logic [7:0] pkt_byte(input logic [1:0] idx, input logic [EVT_W-1:0] e);
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return e[11:4];
      2'd2:    return {4'h0, e[3:0]};
`ifdef NOTE_UART_CHECKSUM_EN
      default: return SYNC_BYTE ^ e[11:4] ^ {4'h0, e[3:0]};
`else
      default: return SYNC_BYTE;
`endif
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_idx;
  logic [7:0]       shift;
  logic [EVT_W-1:0] evt;
  logic             tx_r;
  logic             overflow_r;

  logic [EVT_W-1:0] rdata;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             pop;
  logic             drop;
  logic             baud_end;

  assign pop      = (state == IDLE) & ~empty;
  assign drop     = bus.new_note & full & ~pop;
  assign baud_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  note_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.new_note),
    .pop   (pop),
    .wdata ({bus.note, bus.note_dur}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset)     overflow_r <= 1'b0;
    else if (drop) overflow_r <= 1'b1;
  end

  // UART framing: every state runs for BAUD_DIV clocks; tx is updated together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_r     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_r     <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            state    <= START;
            tx_r     <= 1'b0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_r     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_r  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx < LAST) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
              tx_r     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_r  <= 1'b1;
        end
      endcase
    end
  end

  // Event latch and shift register follow the FSM's load/shift points; no reset needed on data.
  always_ff @(posedge clk) begin
    if (pop) begin
      evt   <= rdata;
      shift <= SYNC_BYTE;
    end else if (state == DATA && baud_end) begin
      shift <= shift >> 1;
    end else if (state == STOP && baud_end && byte_idx < LAST) begin
      shift <= pkt_byte(byte_idx + 1'b1, evt);
    end
  end

  assign bus.tx        = tx_r;
  assign bus.busy      = (state != IDLE) | ~empty;
  assign bus.fifo_full = (count == (AW + 1)'(FIFO_DEPTH));
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_note_event_uart.sv
// Scoreboard bench for note_event_uart: a UART receiver monitor decodes tx and checks against queued bytes.
module tb_note_event_uart;
  import note_uart_pkg::*;

  localparam int CLK_HZ = 1_152_000;
  localparam int BAUD   = 115_200;
  localparam int DIV    = 10;
  localparam int HALF   = DIV / 2;
`ifdef NOTE_UART_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam int PKT_CLKS = NBYTES * 10 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  note_event_uart_if bus ();

  note_event_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [7:0] n, input logic [3:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(n);
    exp_q.push_back({4'h0, d});
`ifdef NOTE_UART_CHECKSUM_EN
    exp_q.push_back(8'hA5 ^ n ^ {4'h0, d});
`endif
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("busy_timeout", 32'(bus.busy), 32'(0));
  endtask

  // Monitor: UART receiver sampling mid-bit on negedges; pops the scoreboard at each stop bit.
  initial begin : monitor
    int         cnt;
    bit         act;
    logic [7:0] sh;
    logic [7:0] exp_b;
    act = 1'b0;
    cnt = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (bus.tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == HALF) begin
          check("start_bit", 32'(bus.tx), 32'(0));
        end else if (cnt > HALF && cnt < HALF + 9 * DIV && (cnt - HALF) % DIV == 0) begin
          sh = {bus.tx, sh[7:1]};
        end else if (cnt == HALF + 9 * DIV) begin
          check("stop_bit", 32'(bus.tx), 32'(1));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", sh);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", 32'(sh), 32'(exp_b));
          end
          act = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int  n;
    int  trans;
    bit  full_seen;
    logic prev;
    bus.note     = '0;
    bus.note_dur = '0;
    bus.new_note = 1'b0;

    // 1: reset and quiet line
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx", 32'(bus.tx), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_full", 32'(bus.fifo_full), 32'(0));
    check("rst_ovf", 32'(bus.overflow), 32'(0));
    trans = 0;
    prev  = bus.tx;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== prev) trans++;
      prev = bus.tx;
    end
    check("idle_transitions", 32'(trans), 32'(0));

    // 2: single event, latency and frame length
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h2D);
    exp_q.push_back(8'h04);
`ifdef NOTE_UART_CHECKSUM_EN
    exp_q.push_back(8'h8C);
`endif
    bus.note = 8'h2D; bus.note_dur = 4'h4; bus.new_note = 1'b1;
    @(negedge clk);
    bus.new_note = 1'b0;
    check("lat_tx_t1", 32'(bus.tx), 32'(1));
    @(negedge clk);
    check("lat_tx_t2", 32'(bus.tx), 32'(0));
    wait_idle(2000, n);
    check("frame_clks", 32'(n), 32'(PKT_CLKS));
    check("q_empty_single", 32'(exp_q.size()), 32'(0));

    // 3: burst of 18 strobes, last one dropped
    full_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.note = 8'(i); bus.note_dur = 4'(i); bus.new_note = 1'b1;
      if (i < 17) push_pkt(8'(i), 4'(i));
      @(negedge clk);
      if (bus.fifo_full) full_seen = 1'b1;
    end
    bus.new_note = 1'b0;
    check("burst_full_seen", 32'(full_seen), 32'(1));
    check("burst_ovf", 32'(bus.overflow), 32'(1));
    wait_idle(20 * PKT_CLKS, n);
    check("burst_ovf_sticky", 32'(bus.overflow), 32'(1));
    check("q_empty_burst", 32'(exp_q.size()), 32'(0));

    // 4: reset in the middle of byte1 data bits, with a second event queued
    bus.note = 8'h11; bus.note_dur = 4'h3; bus.new_note = 1'b1;
    @(negedge clk);
    bus.note = 8'h22; bus.note_dur = 4'h5;
    @(negedge clk);
    bus.new_note = 1'b0;
    check("r4_tx_start", 32'(bus.tx), 32'(0));
    push_pkt(8'h11, 4'h3);
    repeat (146) @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("r4_tx", 32'(bus.tx), 32'(1));
    check("r4_busy", 32'(bus.busy), 32'(0));
    check("r4_ovf", 32'(bus.overflow), 32'(0));
    check("r4_full", 32'(bus.fifo_full), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("r4_stay_idle", 32'(bus.busy), 32'(0));
    push_pkt(8'h3C, 4'hA);
    bus.note = 8'h3C; bus.note_dur = 4'hA; bus.new_note = 1'b1;
    @(negedge clk);
    bus.new_note = 1'b0;
    wait_idle(2000, n);
    check("q_empty_after_rst", 32'(exp_q.size()), 32'(0));

    // 5: push arrives on the exact cycle the FSM pops from a full FIFO
    for (int k = 0; k < 17; k++) begin
      bus.note = 8'(8'h40 + k); bus.note_dur = 4'(k); bus.new_note = 1'b1;
      push_pkt(8'(8'h40 + k), 4'(k));
      @(negedge clk);
    end
    bus.new_note = 1'b0;
    repeat (PKT_CLKS + 2 - 17) @(negedge clk);
    check("pp_full_before", 32'(bus.fifo_full), 32'(1));
    check("pp_gap_tx", 32'(bus.tx), 32'(1));
    bus.note = 8'h51; bus.note_dur = 4'hF; bus.new_note = 1'b1;
    push_pkt(8'h51, 4'hF);
    @(negedge clk);
    bus.new_note = 1'b0;
    check("pp_full_after", 32'(bus.fifo_full), 32'(1));
    check("pp_ovf", 32'(bus.overflow), 32'(0));
    wait_idle(20 * PKT_CLKS, n);
    check("pp_ovf_end", 32'(bus.overflow), 32'(0));
    check("q_empty_pp", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
